// File: rtl/RV32I_Inst_Pkg.sv
// RV32I_Inst_Pkg: shared instruction constants plus the IF/ID packet type and stage state encoding.
package RV32I_Inst_Pkg;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int IF_ID_XLEN = 32;
  localparam int IF_ID_ILEN = 32;
  localparam int IF_ID_NUM_LANES = 1;
  typedef struct packed {
    logic [IF_ID_NUM_LANES-1:0] lane_valid;
    logic [IF_ID_NUM_LANES*IF_ID_ILEN-1:0] instr;
    logic [IF_ID_XLEN-1:0] pc;
  } if_id_pkt_t;
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL = 2'b01,
    SKID = 2'b11
  } if_id_state_e;
endpackage

// File: rtl/if_id_slot.sv
// if_id_slot: one packet register; reset wipes everything, clr only invalidates, load captures a packet.
module if_id_slot #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int NUM_LANES = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  input logic clr,
  input logic load,
  input logic [NUM_LANES-1:0] new_lane_valid,
  input logic [NUM_LANES*ILEN-1:0] new_instr,
  input logic [XLEN-1:0] new_pc,
  output logic valid,
  output logic [NUM_LANES-1:0] lane_valid,
  output logic [NUM_LANES*ILEN-1:0] instr,
  output logic [XLEN-1:0] pc
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      lane_valid <= '0;
      instr <= '0;
      pc <= RESET_PC;
    end else if (clr) begin
      valid <= 1'b0;
      lane_valid <= '0;
    end else if (load) begin
      valid <= 1'b1;
      lane_valid <= new_lane_valid;
      instr <= new_instr;
      pc <= new_pc;
    end
  end
endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: valid/ready IF/ID stage with a 2-entry skid buffer and NOP bubbles to decode.
// Optional perf counters (stall_cycles, flushed_pkts) when IF_ID_PERF_CNT_EN is defined.
module if_id_skid_reg
  import RV32I_Inst_Pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int NUM_LANES = 1,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst_sync,
  input logic flush,
  input logic in_valid,
  output logic in_ready,
  input logic [NUM_LANES*ILEN-1:0] in_instr,
  input logic [NUM_LANES-1:0] in_lane_valid,
  input logic [XLEN-1:0] in_pc,
  output logic out_valid,
  input logic out_ready,
  output logic [NUM_LANES*ILEN-1:0] out_instr,
  output logic [NUM_LANES-1:0] out_lane_valid,
  output logic [XLEN-1:0] out_pc
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flushed_pkts
`endif
);
  logic m_valid, s_valid;
  logic [NUM_LANES-1:0] m_lane_valid, s_lane_valid;
  logic [NUM_LANES*ILEN-1:0] m_instr, s_instr;
  logic [XLEN-1:0] m_pc, s_pc;
  logic in_fire, out_fire, m_load, m_clr, s_load, s_clr;
  if_id_state_e state;
  assign state = if_id_state_e'({s_valid, m_valid});
  assign in_fire = in_valid && in_ready;
  assign out_fire = m_valid && out_ready;
  assign m_load = state == EMPTY ? in_fire : state == FULL ? in_fire && out_fire : out_fire;
  assign m_clr = flush || (state == FULL && out_fire && !in_fire);
  assign s_load = state == FULL && in_fire && !out_fire;
  assign s_clr = flush || (state == SKID && out_fire);
  if_id_slot #(.XLEN(XLEN), .ILEN(ILEN), .NUM_LANES(NUM_LANES), .RESET_PC(RESET_PC)) u_main (
    .clk(clk),
    .rst(rst_sync),
    .clr(m_clr),
    .load(m_load),
    .new_lane_valid(state == SKID ? s_lane_valid : in_lane_valid),
    .new_instr(state == SKID ? s_instr : in_instr),
    .new_pc(state == SKID ? s_pc : in_pc),
    .valid(m_valid),
    .lane_valid(m_lane_valid),
    .instr(m_instr),
    .pc(m_pc)
  );
  if_id_slot #(.XLEN(XLEN), .ILEN(ILEN), .NUM_LANES(NUM_LANES), .RESET_PC(RESET_PC)) u_skid (
    .clk(clk),
    .rst(rst_sync),
    .clr(s_clr),
    .load(s_load),
    .new_lane_valid(in_lane_valid),
    .new_instr(in_instr),
    .new_pc(in_pc),
    .valid(s_valid),
    .lane_valid(s_lane_valid),
    .instr(s_instr),
    .pc(s_pc)
  );
  // in_ready is the registered inverse of next-cycle skid occupancy, so out_ready never reaches it combinationally
  always_ff @(posedge clk) begin
    if (rst_sync || flush) in_ready <= 1'b1;
    else in_ready <= !(s_load || (s_valid && !out_fire));
  end
  assign out_valid = m_valid;
  assign out_pc = m_pc;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign out_lane_valid[i] = m_valid && m_lane_valid[i];
    assign out_instr[i*ILEN +: ILEN] = out_lane_valid[i] ? m_instr[i*ILEN +: ILEN] : ILEN'(INST_NOP);
  end
`ifdef IF_ID_PERF_CNT_EN
  logic [32:0] stall_sum, flush_sum;
  assign stall_sum = {1'b0, stall_cycles} + 33'(in_valid && !in_ready);
  assign flush_sum = {1'b0, flushed_pkts} + (flush ? 33'(m_valid) + 33'(s_valid) : 33'd0);
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      stall_cycles <= '0;
      flushed_pkts <= '0;
    end else begin
      stall_cycles <= stall_sum[32] ? '1 : stall_sum[31:0];
      flushed_pkts <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: table-driven cycle vectors plus a queue scoreboard for if_id_skid_reg (2 lanes).
module tb_if_id_skid_reg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_1000;
  localparam logic [63:0] NOP2 = {NOP, NOP};
  logic clk = 1'b0, rst_sync = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [63:0] in_instr = '0, out_instr;
  logic [1:0] in_lane_valid = '0, out_lane_valid;
  logic [31:0] in_pc = '0, out_pc;
  int tests = 0, fails = 0;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cycles, flushed_pkts;
`endif
  if_id_skid_reg #(.XLEN(32), .ILEN(32), .NUM_LANES(2), .RESET_PC(RPC)) dut (
    .clk(clk),
    .rst_sync(rst_sync),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_instr(in_instr),
    .in_lane_valid(in_lane_valid),
    .in_pc(in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_lane_valid(out_lane_valid),
    .out_pc(out_pc)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flushed_pkts(flushed_pkts)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pc;
    logic [1:0] lv;
    logic [63:0] ins;
  } exp_t;
  exp_t sb[$];
  typedef struct {
    logic rst, flush, iv;
    logic [1:0] ilv;
    logic [63:0] ins;
    logic [31:0] ipc;
    logic ordy, eov, eir;
    logic [31:0] epc;
    logic [1:0] elv;
    logic [63:0] eins;
  } vec_t;
  vec_t v[23];
  function automatic logic [31:0] hi(input logic [31:0] pc);
    return 32'h1000_0000 | pc;
  endfunction
  function automatic logic [63:0] pk(input logic [31:0] pc);
    return {hi(pc), 32'h2000_0000 | pc};
  endfunction
  function automatic vec_t row(input logic r, f, iv, input logic [1:0] ilv, input logic [63:0] ins,
                               input logic [31:0] ipc, input logic ordy, eov, eir,
                               input logic [31:0] epc, input logic [1:0] elv, input logic [63:0] eins);
    vec_t x;
    x.rst = r; x.flush = f; x.iv = iv; x.ilv = ilv; x.ins = ins; x.ipc = ipc; x.ordy = ordy;
    x.eov = eov; x.eir = eir; x.epc = epc; x.elv = elv; x.eins = eins;
    return x;
  endfunction
  function automatic logic [63:0] mask(input logic [1:0] lv, input logic [63:0] ins);
    logic [63:0] m;
    m[31:0] = lv[0] ? ins[31:0] : NOP;
    m[63:32] = lv[1] ? ins[63:32] : NOP;
    return m;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // scoreboard: pop on out-fire, push on in-fire; flush/reset discard everything pending
  always @(negedge clk) begin
    if (rst_sync || flush) sb.delete();
    else begin
      if (!in_ready) chk("skid_without_main", {63'd0, out_valid}, 64'd1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output_pc", {32'd0, out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_pc", {32'd0, out_pc}, {32'd0, e.pc});
          chk("sb_lane_valid", {62'd0, out_lane_valid}, {62'd0, e.lv});
          chk("sb_instr", out_instr, e.ins);
        end
      end
      if (in_valid && in_ready) sb.push_back('{pc: in_pc, lv: in_lane_valid, ins: mask(in_lane_valid, in_instr)});
    end
  end
  initial begin
    int n, cyc;
    logic fire;
    v[0] = row(1, 0, 0, 0, 0, 0, 0, 0, 1, RPC, 0, NOP2);
    v[1] = row(1, 0, 0, 0, 0, 0, 0, 0, 1, RPC, 0, NOP2);
    v[2] = row(0, 0, 1, 3, {32'h00A00113, 32'h00500093}, 32'h100, 1, 1, 1, 32'h100, 3, {32'h00A00113, 32'h00500093});
    v[3] = row(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h100, 0, NOP2);
    v[4] = row(0, 0, 1, 3, pk(0), 0, 0, 1, 1, 0, 3, pk(0));
    v[5] = row(0, 0, 1, 3, pk(4), 4, 0, 1, 0, 0, 3, pk(0));
    v[6] = row(0, 0, 1, 3, pk(8), 8, 0, 1, 0, 0, 3, pk(0));
    v[7] = row(0, 0, 1, 3, pk(8), 8, 1, 1, 1, 4, 3, pk(4));
    v[8] = row(0, 0, 1, 3, pk(8), 8, 1, 1, 1, 8, 3, pk(8));
    v[9] = row(0, 0, 0, 0, 0, 0, 1, 0, 1, 8, 0, NOP2);
    v[10] = row(0, 0, 1, 3, pk(32'h20), 32'h20, 0, 1, 1, 32'h20, 3, pk(32'h20));
    v[11] = row(0, 0, 1, 3, pk(32'h24), 32'h24, 0, 1, 0, 32'h20, 3, pk(32'h20));
    v[12] = row(0, 1, 1, 3, pk(32'h28), 32'h28, 0, 0, 1, 32'h20, 0, NOP2);
    v[13] = row(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20, 0, NOP2);
    v[14] = row(0, 0, 1, 3, pk(32'h30), 32'h30, 0, 1, 1, 32'h30, 3, pk(32'h30));
    v[15] = row(0, 1, 1, 3, pk(32'h34), 32'h34, 0, 0, 1, 32'h30, 0, NOP2);
    v[16] = row(0, 0, 1, 2'b10, pk(32'h40), 32'h40, 1, 1, 1, 32'h40, 2'b10, {hi(32'h40), NOP});
    v[17] = row(0, 0, 1, 0, pk(32'h44), 32'h44, 1, 1, 1, 32'h44, 0, NOP2);
    v[18] = row(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h44, 0, NOP2);
    v[19] = row(0, 0, 1, 3, pk(32'h50), 32'h50, 0, 1, 1, 32'h50, 3, pk(32'h50));
    v[20] = row(0, 0, 1, 3, pk(32'h54), 32'h54, 0, 1, 0, 32'h50, 3, pk(32'h50));
    v[21] = row(1, 0, 0, 0, 0, 0, 0, 0, 1, RPC, 0, NOP2);
    v[22] = row(0, 0, 0, 3, pk(32'hBAD), 32'hBAD, 1, 0, 1, RPC, 0, NOP2);
    for (int i = 0; i < 23; i++) begin
      rst_sync = v[i].rst; flush = v[i].flush; in_valid = v[i].iv; in_lane_valid = v[i].ilv;
      in_instr = v[i].ins; in_pc = v[i].ipc; out_ready = v[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("row%0d_out_valid", i), {63'd0, out_valid}, {63'd0, v[i].eov});
      chk($sformatf("row%0d_in_ready", i), {63'd0, in_ready}, {63'd0, v[i].eir});
      chk($sformatf("row%0d_out_pc", i), {32'd0, out_pc}, {32'd0, v[i].epc});
      chk($sformatf("row%0d_lane_valid", i), {62'd0, out_lane_valid}, {62'd0, v[i].elv});
      chk($sformatf("row%0d_out_instr", i), out_instr, v[i].eins);
`ifdef IF_ID_PERF_CNT_EN
      if (i == 12) begin
        chk("flushed_pkts_skid", {32'd0, flushed_pkts}, 64'd2);
        chk("stall_cycles_bp", {32'd0, stall_cycles}, 64'd3);
      end
`endif
    end
    rst_sync = 0; flush = 0;
    for (int k = 0; k < 100; k++) begin
      in_valid = 1; in_lane_valid = 2'b11; in_pc = 32'h2000 + 32'(4 * k); in_instr = pk(in_pc); out_ready = 1;
      @(posedge clk); #1;
      chk("tp_in_ready", {63'd0, in_ready}, 64'd1);
      chk("tp_out_pc", {32'd0, out_pc}, {32'd0, 32'h2000 + 32'(4 * k)});
    end
    in_valid = 0;
    @(posedge clk); #1;
    chk("tp_drained", {63'd0, out_valid}, 64'd0);
`ifdef IF_ID_PERF_CNT_EN
    chk("tp_stall_cycles", {32'd0, stall_cycles}, 64'd0);
`endif
    n = 0; cyc = 0;
    while (n < 1000 && cyc < 20000) begin
      in_valid = 1; in_pc = 32'h10000 + 32'(4 * n);
      if (!fire || cyc == 0) begin
        in_lane_valid = 2'($urandom); in_instr = {$urandom, $urandom};
      end
      out_ready = 1'($urandom);
      fire = in_ready;
      @(posedge clk); #1;
      if (fire) n++;
      cyc++;
    end
    chk("rand_all_accepted", 64'(n), 64'd1000);
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rand_sb_empty", 64'(sb.size()), 64'd0);
    chk("rand_final_out_valid", {63'd0, out_valid}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Next-generation IF/ID pipeline stage. Replaces the bare stall/flush register with a valid/ready handshaked, 2-entry skid-buffered stage.
- Carries a fetch packet of NUM_LANES instructions plus one packet PC.
- Fetch can be back-pressured without a combinational ready path from decode.
- Presents NOP bubbles to decode whenever the stage is empty, flushed or in reset.

Parameters:
- XLEN, 32, PC width.
- ILEN, 32, instruction width per lane.
- NUM_LANES, 1, instructions per fetch packet (1..4).
- RESET_PC, 32'h0000_0000, value of out_pc after reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_sync  in  1  synchronous active-high reset.
- flush  in  1  discard all buffered packets (branch/exception redirect).
- in_valid  in  1  fetch packet valid.
- in_ready  out  1  stage can accept a packet. Registered; equals !skid_valid.
- in_instr  in  NUM_LANES*ILEN  packet instructions, lane 0 in LSBs.
- in_lane_valid  in  NUM_LANES  per-lane valid (partial packets after a mid-packet branch target).
- in_pc  in  XLEN  PC of lane 0.
- out_valid  out  1  packet presented to decode.
- out_ready  in  1  decode accepts the packet.
- out_instr  out  NUM_LANES*ILEN  packet to decode. Each lane is INST_NOP when the lane is invalid or out_valid=0.
- out_lane_valid  out  NUM_LANES  0 when out_valid=0.
- out_pc  out  XLEN  PC of the presented packet; holds the last value when empty.

Behaviour:
- Clocking and reset: single clock clk; reset rst_sync is synchronous and active-high.
- Storage: main slot M (drives the outputs) and skid slot S, each holding {valid, lane_valid, instr, pc}.
- In-handshake: fires when in_valid && in_ready.
- Out-handshake: fires when out_valid && out_ready.
- State machine, encoded by {S.valid, M.valid}:
  - EMPTY (0,0): an in-fire loads M, go to FULL.
  - FULL (0,1):
    - in-fire with out-fire: M reloads from the input, stay FULL.
    - in-fire without out-fire: load S, go to SKID.
    - out-fire without in-fire: go to EMPTY.
  - SKID (1,1): in_ready=0.
    - out-fire: M <= S, clear S, go to FULL.
    - no out-fire: hold.
  - (1,0) is illegal and must never occur.
- Latency: 1 cycle from in-fire to out_valid. The throughput at 100% ready is 1 packet per cycle.
- in_ready is a flop output with no combinational path from out_ready.
- flush:
  - Next cycle is EMPTY. S and M valid bits and lane_valids are cleared.
  - An input fire in the flush cycle is discarded.
  - out_pc keeps its value.
  - in_ready=1 in the cycle after the flush.
- rst_sync:
  - Same as flush.
  - Additionally out_pc <= RESET_PC and the instr fields are cleared.
  - Reset mid-transfer discards both slots.
  - rst_sync has priority over flush; flush has priority over the handshakes.
- NOP insertion is combinational on the outputs from M.valid/lane_valid. Stored data is not rewritten.
- A packet with in_valid=1 and in_lane_valid=0 is accepted and presented as an all-NOP packet with out_valid=1. It is not dropped.
- in_* and out_ready values are don't-care when the corresponding valid is low. The stage must not capture garbage into a valid slot.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles[31:0]: counts cycles with in_valid && !in_ready.
  - Adds output flushed_pkts[31:0]: adds the number of valid slots discarded by flush, 0..2 per flush.
  - Both counters clear on rst_sync, saturate at 32'hFFFF_FFFF and are not cleared by flush.
- Undefined: the counters and their ports are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package RV32I_Inst_Pkg gains:
  - INST_NOP (already present).
  - typedef if_id_pkt_t, a parametrisation-friendly struct {lane_valid, instr, pc} built from XLEN/ILEN/NUM_LANES localparams.
  - enum if_id_state_e {EMPTY, FULL, SKID}.
- Sub-module if_id_slot: one slot register with load/clear controls, instantiated twice for M and S.

Test Plan:
- Reset then single packet: rst_sync 2 cycles, then in_valid=1, in_pc=32'h100, instr=32'h00500093, out_ready=1. Expect:
  - out_valid=0, out_instr=INST_NOP, out_pc=RESET_PC during reset.
  - Next cycle: out_valid=1, out_pc=32'h100, out_instr=32'h00500093.
- Back-pressure: stream PCs 0x0,0x4,0x8 with out_ready=0. Expect:
  - Packets 0x0 and 0x4 accepted; in_ready=0 the cycle after 0x4 is accepted; 0x8 held by fetch.
  - After out_ready=1, packets appear in order 0x0,0x4,0x8 with no loss or duplication.
- Flush in SKID: fill M=0x20, S=0x24, assert flush together with in_valid (PC 0x28). Expect:
  - Next cycle: out_valid=0, out_instr=NOP, in_ready=1.
  - Neither 0x24 nor 0x28 ever appears.
  - flushed_pkts=2 with IF_ID_PERF_CNT_EN.
- Partial packet (NUM_LANES=2): in_lane_valid=2'b10, in_pc=32'h40. Expect:
  - out_valid=1, out_lane_valid=2'b10.
  - Lane 0 = INST_NOP, lane 1 = input instruction.
- Full throughput: 100 consecutive packets, out_ready=1 throughout. Expect:
  - in_ready stays 1.
  - Output PCs follow input PCs with exactly 1-cycle latency.
  - stall_cycles=0.
- Randomised out_ready at 50% over 1000 packets. Expect:
  - Scoreboard order matches.
  - State (1,0) never observed (assertion).
